// File: rtl/sensor_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// sensor_conditioner_pkg
// Shared definitions for the tank-level front end:
//   - Nivel level codes (empty / low / mid / high)
//   - error cause codes reported on err_code
//   - helpers that classify and encode a filtered (L,M,H) probe combination
// -----------------------------------------------------------------------------
package sensor_conditioner_pkg;

    // Level codes presented on nivel
    localparam logic [1:0] NIVEL_VAZIO = 2'd0;
    localparam logic [1:0] NIVEL_BAIXO = 2'd1;
    localparam logic [1:0] NIVEL_MEDIO = 2'd2;
    localparam logic [1:0] NIVEL_ALTO  = 2'd3;

    // Error causes latched into err_code
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_INCONS  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    // Probes sit at increasing heights, so water can only wet them bottom-up.
    // A higher probe wet while a lower one is dry is physically impossible.
    function automatic logic combo_valid(input logic l, input logic m, input logic h);
        logic [2:0] lmh;
        lmh = {l, m, h};
        return (lmh == 3'b000) || (lmh == 3'b100) ||
               (lmh == 3'b110) || (lmh == 3'b111);
    endfunction

    // Level code for a combination; only meaningful when combo_valid() is true.
    function automatic logic [1:0] nivel_encode(input logic l, input logic m, input logic h);
        logic [1:0] code;
        code = NIVEL_VAZIO;
        if (h)      code = NIVEL_ALTO;
        else if (m) code = NIVEL_MEDIO;
        else if (l) code = NIVEL_BAIXO;
        return code;
    endfunction

endpackage

// File: rtl/sensor_conditioner_filtro_debounce.sv
// -----------------------------------------------------------------------------
// filtro_debounce
// One probe channel: a 2-FF synchroniser for the asynchronous raw probe
// followed by a debounce counter. The filtered level only flips after the
// synchronised value has disagreed with it for DEBOUNCE_CYCLES consecutive
// samples, so a raw edge sampled at edge k shows up at edge k+2+DEBOUNCE_CYCLES.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   raw       in   raw probe, asynchronous to clk (1 = water present)
//   filtered  out  debounced probe level
// -----------------------------------------------------------------------------
module filtro_debounce
    import sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Synchroniser chain plus debounce counter. Once the counter has
    // accumulated a full run of disagreeing samples the flip happens on the
    // following edge regardless of the current sample, which is what gives
    // the fixed k+2+DEBOUNCE_CYCLES latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (cnt == CNT_MAX) begin
                filtered <= ~filtered;
                cnt      <= '0;
            end else if (sync_b != filtered) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Front end for the irrigation controller: debounces the three tank probes,
// checks that they form a possible combination, encodes the level and runs a
// fill watchdog on the inlet valve. Any problem is latched into e / err_code
// until the controller clears it while no cause is active.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   h_raw        in   raw high probe (asynchronous)
//   m_raw        in   raw mid probe (asynchronous)
//   l_raw        in   raw low probe (asynchronous)
//   ve           in   inlet valve open status
//   err_clear    in   single-cycle request to clear the latched error
//   h, m, l      out  debounced probe levels
//   nivel  [1:0] out  level code (0 empty .. 3 high), holds while inconsistent
//   e            out  latched error
//   err_code [1:0] out first error cause (0 none, 1 inconsistent, 2 timeout)
// -----------------------------------------------------------------------------
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FILL_TIMEOUT    = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_raw,
    input  logic       m_raw,
    input  logic       l_raw,
    input  logic       ve,
    input  logic       err_clear,
    output logic       h,
    output logic       m,
    output logic       l,
    output logic [1:0] nivel,
    output logic       e,
    output logic [1:0] err_code
);

    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(FILL_TIMEOUT);

    logic             h_prev;
    logic             m_prev;
    logic             l_prev;
    logic [CNT_W-1:0] wd;
    err_code_t        err_q;

    logic combo_ok;
    logic cause_incons;
    logic cause_timeout;
    logic any_rise;
    logic wd_clear;

    filtro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (h_raw),
        .filtered (h)
    );

    filtro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (m_raw),
        .filtered (m)
    );

    filtro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (l_raw),
        .filtered (l)
    );

    // Error causes and watchdog clear conditions, all derived from the
    // filtered levels. A rise is seen by comparing against last cycle's
    // filtered value: any rising water proves the fill is progressing.
    always_comb begin
        combo_ok      = combo_valid(l, m, h);
        cause_incons  = !combo_ok;
        cause_timeout = (wd == WD_MAX);
        any_rise      = (h & ~h_prev) | (m & ~m_prev) | (l & ~l_prev);
        wd_clear      = !ve || h || any_rise;
    end

    // Previous filtered levels for rise detection, and the level code that
    // only follows combinations that can physically exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_prev <= 1'b0;
            m_prev <= 1'b0;
            l_prev <= 1'b0;
            nivel  <= NIVEL_VAZIO;
        end else begin
            h_prev <= h;
            m_prev <= m;
            l_prev <= l;
            if (combo_ok) begin
                nivel <= nivel_encode(l, m, h);
            end
        end
    end

    // Fill watchdog: counts valve-open cycles without progress and parks at
    // FILL_TIMEOUT so the timeout cause stays asserted until something clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (wd_clear) begin
            wd <= '0;
        end else if (wd != WD_MAX) begin
            wd <= wd + 1'b1;
        end
    end

    // Error latch: the first cause wins and sticks. A clear request is only
    // honoured when no cause is active in that same cycle; otherwise it is
    // simply dropped. Inconsistency takes priority over a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e     <= 1'b0;
            err_q <= ERR_NONE;
        end else if (err_clear && !cause_incons && !cause_timeout) begin
            e     <= 1'b0;
            err_q <= ERR_NONE;
        end else if (!e && (cause_incons || cause_timeout)) begin
            e     <= 1'b1;
            err_q <= cause_incons ? ERR_INCONS : ERR_TIMEOUT;
        end
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sensor_conditioner
// Scoreboard bench for sensor_conditioner. The driver applies probe/valve
// patterns and, at every clock edge, advances a behavioural model that reasons
// in terms of sample histories (a level flips once the synchronised probe has
// disagreed with it over a full window), "cycles since the last watchdog
// clear", and "number of wet probes" for the level. Expected outputs go into a
// queue; an independent monitor pops and compares them after each edge.
// -----------------------------------------------------------------------------
module tb_sensor_conditioner;

    localparam int D    = 4;
    localparam int FT   = 10;
    localparam int MAXE = 8192;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       h_raw     = 1'b0;
    logic       m_raw     = 1'b0;
    logic       l_raw     = 1'b0;
    logic       ve        = 1'b0;
    logic       err_clear = 1'b0;
    logic       h;
    logic       m;
    logic       l;
    logic [1:0] nivel;
    logic       e;
    logic [1:0] err_code;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .FILL_TIMEOUT    (FT),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_raw     (h_raw),
        .m_raw     (m_raw),
        .l_raw     (l_raw),
        .ve        (ve),
        .err_clear (err_clear),
        .h         (h),
        .m         (m),
        .l         (l),
        .nivel     (nivel),
        .e          (e),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Reference model state; probe index 0 = L, 1 = M, 2 = H.
    bit         raw_hist  [3][MAXE];
    bit         filt_hist [3][MAXE];
    int         last_flip [3];
    int         last_clear;
    int         t_edge;
    int         wd_m;
    bit         e_m;
    logic [1:0] code_m;
    logic [1:0] nivel_m;

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int         n_vec = 0;
    int         n_err = 0;

    // Synchronised probe value the DUT sees just before edge ed.
    function automatic bit sync_pre(input int p, input int ed);
        if (ed >= 3) return raw_hist[p][ed-2];
        return 1'b0;
    endfunction

    function automatic bit filt_at(input int p, input int ed);
        if (ed >= 0) return filt_hist[p][ed];
        return 1'b0;
    endfunction

    function automatic void model_reset();
        t_edge     = 0;
        last_clear = 0;
        wd_m       = 0;
        e_m        = 1'b0;
        code_m     = 2'd0;
        nivel_m    = 2'd0;
        for (int p = 0; p < 3; p++) begin
            last_flip[p]    = 0;
            filt_hist[p][0] = 1'b0;
        end
    endfunction

    // Advance the model by one clock edge using the inputs sampled at it.
    function automatic void model_step();
        bit rin[3];
        bit fl, fm, fh, incons, tmo, rise, prev, flip;
        rin[0] = l_raw;
        rin[1] = m_raw;
        rin[2] = h_raw;
        t_edge++;
        if (t_edge >= MAXE) begin
            $display("[TB] FAIL model_capacity edge=%0d limit=%0d", t_edge, MAXE);
            $fatal(1, "[TB] model history exhausted");
        end
        fl = filt_at(0, t_edge-1);
        fm = filt_at(1, t_edge-1);
        fh = filt_at(2, t_edge-1);
        incons = !(({fl,fm,fh} == 3'b000) || ({fl,fm,fh} == 3'b100) ||
                   ({fl,fm,fh} == 3'b110) || ({fl,fm,fh} == 3'b111));
        tmo  = (wd_m == FT);
        rise = 1'b0;
        for (int p = 0; p < 3; p++)
            if (filt_at(p, t_edge-1) && !filt_at(p, t_edge-2)) rise = 1'b1;

        if (err_clear && !incons && !tmo) begin
            e_m    = 1'b0;
            code_m = 2'd0;
        end else if (!e_m && (incons || tmo)) begin
            e_m    = 1'b1;
            code_m = incons ? 2'd1 : 2'd2;
        end

        if (!incons) nivel_m = 2'(int'(fl) + int'(fm) + int'(fh));

        if (!ve || fh || rise) last_clear = t_edge;
        wd_m = (t_edge - last_clear > FT) ? FT : t_edge - last_clear;

        for (int p = 0; p < 3; p++) begin
            raw_hist[p][t_edge] = rin[p];
            prev = filt_at(p, t_edge-1);
            flip = (t_edge - last_flip[p] >= D + 1);
            for (int i = 1; i <= D; i++)
                if (t_edge - i < 1 || sync_pre(p, t_edge-i) == prev) flip = 1'b0;
            filt_hist[p][t_edge] = flip ? !prev : prev;
            if (flip) last_flip[p] = t_edge;
        end

        exp_q.push_back({filt_hist[2][t_edge], filt_hist[1][t_edge], filt_hist[0][t_edge],
                         nivel_m, e_m, code_m});
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s t=%0t h,m,l,nivel,e,code got %b required %b",
                     name, $time, act, req);
        end
    endtask

    // Hold a pattern for n edges; err_clear is only asserted for the first.
    task automatic applyStimulus(input bit lr, input bit mr, input bit hr,
                                 input bit v, input bit clr, input int n);
        l_raw     = lr;
        m_raw     = mr;
        h_raw     = hr;
        ve        = v;
        err_clear = clr;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #3;
            err_clear = 1'b0;
        end
    endtask

    // Mid-cycle asynchronous reset, checked immediately, released mid-cycle.
    task automatic doReset(input int n);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {h, m, l, nivel, e, err_code}, 8'h00);
        model_reset();
        repeat (n) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares each edge's outputs against the scoreboard entry.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checkOutput("cycle", {h, m, l, nivel, e, err_code}, exp_v);
        end
    end

    initial begin
        int lvl;
        bit lr, mr, hr;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_state", {h, m, l, nivel, e, err_code}, 8'h00);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Clean fill then drain, valve closed
        applyStimulus(0, 0, 0, 0, 0, 10);
        applyStimulus(1, 0, 0, 0, 0, 20);
        applyStimulus(1, 1, 0, 0, 0, 20);
        applyStimulus(1, 1, 1, 0, 0, 20);
        applyStimulus(1, 1, 0, 0, 0, 20);
        applyStimulus(1, 0, 0, 0, 0, 20);

        // Glitches on M: 3 cycles filtered out, 4 cycles propagate
        applyStimulus(1, 1, 0, 0, 0, 3);
        applyStimulus(1, 0, 0, 0, 0, 20);
        applyStimulus(1, 1, 0, 0, 0, 4);
        applyStimulus(1, 0, 0, 0, 0, 20);

        // Inconsistent H-only, clear ignored, then honoured
        applyStimulus(0, 0, 0, 0, 0, 20);
        applyStimulus(0, 0, 1, 0, 0, 12);
        applyStimulus(0, 0, 1, 0, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 12);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 5);

        // Fill timeout at level 1, clear refused while saturated, then accepted
        applyStimulus(1, 0, 0, 0, 0, 20);
        applyStimulus(1, 0, 0, 1, 0, 15);
        applyStimulus(1, 0, 0, 1, 1, 2);
        applyStimulus(1, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 3);

        // M rises before the watchdog expires: no error
        applyStimulus(1, 0, 0, 1, 0, 2);
        applyStimulus(1, 1, 0, 1, 0, 8);
        applyStimulus(1, 1, 0, 0, 0, 10);

        // L drops (010) on the same edge the watchdog saturates
        applyStimulus(1, 1, 0, 1, 0, 3);
        applyStimulus(0, 1, 0, 1, 0, 12);
        applyStimulus(1, 1, 0, 0, 0, 12);
        applyStimulus(1, 1, 0, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 0, 3);

        // Reset mid-fill with nivel=2 and a latched timeout
        applyStimulus(1, 1, 0, 1, 0, 15);
        doReset(3);
        applyStimulus(1, 1, 0, 0, 0, 12);

        // Randomised level walk with glitches, odd combinations and clears
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                lr = 1'($urandom_range(0, 1));
                mr = 1'($urandom_range(0, 1));
                hr = 1'($urandom_range(0, 1));
            end else begin
                lvl = int'($urandom_range(0, 3));
                lr  = (lvl >= 1);
                mr  = (lvl >= 2);
                hr  = (lvl >= 3);
            end
            applyStimulus(lr, mr, hr, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), int'($urandom_range(1, 12)));
            if ($urandom_range(0, 99) == 0) doReset(2);
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drain", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Front-end stage for the irrigation controller FSM. It synchronises and debounces the three raw tank-level probes, checks that they form a physically possible combination, and runs a fill watchdog on the inlet valve. It presents clean H/M/L levels and the error flag E to the controller, so that controller never acts on glitching probes.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a filtered level changes (≥1).
- FILL_TIMEOUT, 1000: cycles of Ve=1 with no level rise before a fill-timeout error (≥2).
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > FILL_TIMEOUT.

- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- H_raw, M_raw, L_raw  in  1 each  raw high/mid/low probe, asynchronous to Clock; 1 = water present.
- Ve  in  1  inlet-valve-open status from the controller.
- Err_clear  in  1  single-cycle request to clear a latched error.
- H, M, L  out  1 each  debounced probe levels.
- Nivel  out  2  level code: 0 empty, 1 low, 2 mid, 3 high.
- E  out  1  latched error to the controller.
- Err_code  out  2  0 none, 1 inconsistent probes, 2 fill timeout.

## Operation
- Reset values: H=M=L=0, Nivel=0, E=0, Err_code=0; all synchronisers, debounce counters and the watchdog are 0.
- Per probe:
  - 2-FF synchroniser.
  - Debounce counter counts while the synchronised value ≠ filtered value, and clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the filtered value flips and the counter clears.
- Valid (L,M,H) combinations: 000, 100, 110, 111. Any other combination is inconsistent.
- Nivel follows valid combinations (000→0, 100→1, 110→2, 111→3). It holds its last valid value while the combination is inconsistent.
- Watchdog:
  - Cleared while Ve=0, while H=1, and on any cycle where a filtered probe rises 0→1.
  - Otherwise increments while Ve=1, saturating at FILL_TIMEOUT.
  - Reaching FILL_TIMEOUT raises a timeout cause.
- Error latch:
  - E sets on the first cause and stays set.
  - Err_code captures the first cause and is not overwritten by later causes.
  - If both causes occur in the same cycle, code 1 (inconsistent probes) wins.
- Err_clear:
  - Clears E and Err_code to 0 only if no cause is active that cycle: combination valid and watchdog below FILL_TIMEOUT.
  - Otherwise it is ignored and has no deferred effect.
- Ve dropping does not clear E. Only Err_clear or Reset clears E.

## Timing
- A raw edge sampled at edge k appears on the filtered output at edge k+2+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never reach the output.
- Nivel and the inconsistency check are registered: both update 1 cycle after the filtered H/M/L change.
- E and Err_code are registered 1 cycle after the cause becomes active.
- Fill timeout: with Ve=1 and no rise from edge j onward, the watchdog reaches FILL_TIMEOUT at edge j+FILL_TIMEOUT and E rises at edge j+FILL_TIMEOUT+1.
- Err_clear takes effect at the next edge. E=0 is visible 1 cycle after Err_clear is sampled.
- Reset asserted mid-operation forces all outputs to their reset values immediately. Operation restarts from the raw inputs after release.

## Structure
- Shared package:
  - Nivel code constants (NIVEL_VAZIO/BAIXO/MEDIO/ALTO).
  - Err_code constants (ERR_NONE/ERR_INCONS/ERR_TIMEOUT).
  - The valid-combination function.
- One sub-module, `filtro_debounce`: synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES, instantiated 3 times.
- Top level contains the consistency check, Nivel encoding, watchdog and error latch.

## Test plan
- Clean fill: L_raw, then M_raw, then H_raw rise, each held 20 cycles, with DEBOUNCE_CYCLES=4 → Nivel steps 1, 2, 3; each filtered rise occurs exactly 6 cycles after the raw edge; E stays 0.
- Glitch: M_raw pulses high for 3 cycles with L=1 → M stays 0, Nivel stays 1; a 4-cycle pulse propagates to M.
- Inconsistency: H_raw=1 with L_raw=M_raw=0 → E=1 and Err_code=1 one cycle after filtered H=1; Nivel holds 0. Err_clear while H is still 1 is ignored; Err_clear after H returns to 0 → E=0.
- Timeout: FILL_TIMEOUT=10, Ve=1, probes static at 100 → E=1, Err_code=2 at cycle 11. A repeat run where M rises at cycle 8 → no error.
- Simultaneous causes: watchdog at 9 of 10, then an inconsistent combination lands on the same cycle as the timeout → Err_code=1.
- Reset mid-fill: Reset pulled low with Nivel=2, E=1 → all outputs 0 immediately. After release with probes held at 110, Nivel=2 again after 2+DEBOUNCE_CYCLES+1 cycles.
